// File: rtl/opc_mem_responder.sv
// opc_mem_responder: bus target for the OPC CPU memory interface.
// Zero-wait combinational reads and posedge-committed CPU stores into
// on-chip byte RAM. A byte-serial loader (address hi, address lo, data...)
// fills RAM from the pins while the CPU is held in reset via cpu_hold.
// Optional feature macro: OPC_IO_PORT_EN maps an 8-bit I/O port at
// 11'h7FE (input) and 11'h7FF (output register).
module opc_mem_responder #(
    parameter int unsigned MEM_AW  = 9,
    parameter logic [10:0] LD_BASE = 11'h100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] address,
    input  logic        rnw,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    input  logic        ld_start,
    input  logic        ld_valid,
    input  logic [7:0]  ld_byte,
    input  logic        ld_done,
    output logic        ld_ready,
    output logic        cpu_hold,
    input  logic [7:0]  port_in,
    output logic [7:0]  port_out
);

    localparam int unsigned MEM_DEPTH = 2 ** MEM_AW;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        L_AHI  = 2'd1,
        L_ALO  = 2'd2,
        L_DATA = 2'd3
    } ld_state_t;

    ld_state_t   r_state;
    ld_state_t   w_state_nx;
    logic [10:0] r_ptr;
    logic        r_ld_ready;
    logic        r_cpu_hold;
    logic [7:0]  r_mem [MEM_DEPTH];

    logic        w_accept;
    logic        w_ld_we;
    logic        w_cpu_we;
    logic        w_cpu_io;
    logic        w_ptr_io;
    logic        w_cpu_mapped;
    logic        w_ptr_mapped;
    logic [7:0]  w_rdata;

`ifdef OPC_IO_PORT_EN
    logic [7:0]  r_port_out;

    assign w_cpu_io = (address == 11'h7FE) || (address == 11'h7FF);
    assign w_ptr_io = (r_ptr == 11'h7FE) || (r_ptr == 11'h7FF);
`else
    logic        w_unused_port_in;

    assign w_cpu_io         = 1'b0;
    assign w_ptr_io         = 1'b0;
    assign w_unused_port_in = ^port_in;
`endif

    // Port addresses are carved out of the RAM window even if MEM_AW covers them.
    assign w_cpu_mapped = (32'(address) < MEM_DEPTH) && !w_cpu_io;
    assign w_ptr_mapped = (32'(r_ptr) < MEM_DEPTH) && !w_ptr_io;

    assign w_accept = ld_valid && r_ld_ready;
    assign w_cpu_we = !rnw && w_cpu_mapped;

    // Loader next-state decode: ld_start restarts, byte is consumed before ld_done.
    always_comb begin
        w_state_nx = r_state;
        w_ld_we    = 1'b0;
        if (ld_start) begin
            w_state_nx = L_AHI;
        end else if (r_state != IDLE) begin
            if (w_accept) begin
                case (r_state)
                    L_AHI:   w_state_nx = L_ALO;
                    L_ALO:   w_state_nx = L_DATA;
                    L_DATA:  w_ld_we    = w_ptr_mapped;
                    default: w_state_nx = r_state;
                endcase
            end
            if (ld_done) begin
                w_state_nx = IDLE;
            end
        end
    end

    // Loader FSM, load pointer and registered handshake/hold outputs.
    // Outputs are registered from the next state so ld_ready/cpu_hold line up
    // with the state itself; cpu_hold additionally covers the first IDLE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_ptr      <= LD_BASE;
            r_ld_ready <= 1'b0;
            r_cpu_hold <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_ld_ready <= (w_state_nx != IDLE);
            r_cpu_hold <= (w_state_nx != IDLE) || (r_state != IDLE);
            if (w_accept && !ld_start) begin
                case (r_state)
                    L_AHI:   r_ptr[10:8] <= ld_byte[2:0];
                    L_ALO:   r_ptr[7:0]  <= ld_byte;
                    L_DATA:  r_ptr       <= r_ptr + 11'd1;
                    default: r_ptr       <= r_ptr;
                endcase
            end
        end
    end

    // RAM write port: loader has priority over a simultaneous CPU store.
    always_ff @(posedge clk) begin
        if (w_ld_we) begin
            r_mem[r_ptr[MEM_AW-1:0]] <= ld_byte;
        end else if (w_cpu_we) begin
            r_mem[address[MEM_AW-1:0]] <= wdata;
        end
    end

`ifdef OPC_IO_PORT_EN
    // Output port register, written by CPU stores to 11'h7FF.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_port_out <= '0;
        end else if (!rnw && (address == 11'h7FF)) begin
            r_port_out <= wdata;
        end
    end

    assign port_out = r_port_out;

    // Read mux: I/O port, then RAM, otherwise zero.
    always_comb begin
        w_rdata = '0;
        if (address == 11'h7FF) begin
            w_rdata = r_port_out;
        end else if (address == 11'h7FE) begin
            w_rdata = port_in;
        end else if (w_cpu_mapped) begin
            w_rdata = r_mem[address[MEM_AW-1:0]];
        end
    end
`else
    assign port_out = '0;

    // Read mux: RAM when mapped, otherwise zero.
    always_comb begin
        w_rdata = '0;
        if (w_cpu_mapped) begin
            w_rdata = r_mem[address[MEM_AW-1:0]];
        end
    end
`endif

    assign rdata    = w_rdata;
    assign ld_ready = r_ld_ready;
    assign cpu_hold = r_cpu_hold;

endmodule

// File: tb/tb_opc_mem_responder.sv
// Testbench for opc_mem_responder: directed vectors, a byte-level model of
// the loader protocol and RAM checked every cycle, plus literal checks.
module tb_opc_mem_responder;

    localparam int unsigned RAM_BYTES = 512;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] address = '0;
    logic        rnw = 1'b1;
    logic [7:0]  wdata = '0;
    logic [7:0]  rdata;
    logic        ld_start = 1'b0;
    logic        ld_valid = 1'b0;
    logic [7:0]  ld_byte = '0;
    logic        ld_done = 1'b0;
    logic        ld_ready;
    logic        cpu_hold;
    logic [7:0]  port_in = '0;
    logic [7:0]  port_out;

    int n_cmp = 0;
    int n_bad = 0;

    opc_mem_responder #(.MEM_AW(9), .LD_BASE(11'h100)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .address  (address),
        .rnw      (rnw),
        .wdata    (wdata),
        .rdata    (rdata),
        .ld_start (ld_start),
        .ld_valid (ld_valid),
        .ld_byte  (ld_byte),
        .ld_done  (ld_done),
        .ld_ready (ld_ready),
        .cpu_hold (cpu_hold),
        .port_in  (port_in),
        .port_out (port_out)
    );

    always #5 clk = ~clk;

    // ---------------- model ----------------
    logic [7:0] m_mem [2048];
    bit         m_known [2048];
    bit         m_loading = 1'b0;
    bit         m_was = 1'b0;
    int         m_nbytes = 0;
    logic [2:0] m_hi = '0;
    logic [7:0] m_lo = '0;
    logic [7:0] m_port = '0;

    function automatic bit is_io(input logic [10:0] a);
`ifdef OPC_IO_PORT_EN
        return (a == 11'h7FE) || (a == 11'h7FF);
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit is_ram(input logic [10:0] a);
        return (32'(a) < RAM_BYTES) && !is_io(a);
    endfunction

    // Model: bytes since ld_start are counted; first two form the base address,
    // data byte k lands at base + k (mod 2048).
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_loading = 1'b0;
                m_was     = 1'b0;
                m_nbytes  = 0;
                m_port    = '0;
            end else begin
                bit          ldw;
                logic [10:0] la;
                ldw   = 1'b0;
                m_was = m_loading;
                if (ld_start) begin
                    m_loading = 1'b1;
                    m_nbytes  = 0;
                end else if (m_loading) begin
                    if (ld_valid) begin
                        if (m_nbytes == 0) begin
                            m_hi = ld_byte[2:0];
                        end else if (m_nbytes == 1) begin
                            m_lo = ld_byte;
                        end else begin
                            la = {m_hi, m_lo} + 11'(m_nbytes - 2);
                            if (is_ram(la)) begin
                                m_mem[la]   = ld_byte;
                                m_known[la] = 1'b1;
                                ldw         = 1'b1;
                            end
                        end
                        m_nbytes++;
                    end
                    if (ld_done) m_loading = 1'b0;
                end
                if (!rnw && !ldw && is_ram(address)) begin
                    m_mem[address]   = wdata;
                    m_known[address] = 1'b1;
                end
                if (!rnw && is_io(address) && (address == 11'h7FF)) m_port = wdata;
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t actual=%02h required=%02h", name, $time, act, exp);
        end
    endtask

    // Per-cycle compare against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("hold", {7'b0, cpu_hold}, {7'b0, m_loading || m_was});
            chk("ready", {7'b0, ld_ready}, {7'b0, m_loading});
            chk("port_out", port_out, m_port);
            if (is_io(address)) begin
                chk("rdata_io", rdata, (address == 11'h7FF) ? m_port : port_in);
            end else if (!is_ram(address)) begin
                chk("rdata_unmapped", rdata, 8'h00);
            end else if (m_known[address]) begin
                chk("rdata_ram", rdata, m_mem[address]);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input bit done);
        ld_valid = 1'b1;
        ld_byte  = b;
        ld_done  = done;
        step();
        ld_valid = 1'b0;
        ld_done  = 1'b0;
    endtask

    task automatic start();
        ld_start = 1'b1;
        step();
        ld_start = 1'b0;
    endtask

    task automatic cpu_wr(input logic [10:0] a, input logic [7:0] d);
        rnw     = 1'b0;
        address = a;
        wdata   = d;
        step();
        rnw     = 1'b1;
    endtask

    task automatic rd_lit(input string name, input logic [10:0] a, input logic [7:0] exp);
        address = a;
        #2;
        chk(name, rdata, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 1: reset state
        address = 11'h600;
        #2;
        chk("t1_hold", {7'b0, cpu_hold}, 8'h00);
        chk("t1_ready", {7'b0, ld_ready}, 8'h00);
        chk("t1_port", port_out, 8'h00);
        chk("t1_rdata600", rdata, 8'h00);

        // Bytes and ld_done offered in IDLE are ignored
        send(8'h55, 1'b1);
        chk("idle_hold", {7'b0, cpu_hold}, 8'h00);

        // 2: basic load at 0x100, ld_done with last byte
        start();
        #2;
        chk("t2_hold_on", {7'b0, cpu_hold}, 8'h01);
        chk("t2_ready_on", {7'b0, ld_ready}, 8'h01);
        send(8'h01, 1'b0);
        send(8'h00, 1'b0);
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b0);
        send(8'hCC, 1'b1);
        #2;
        chk("t2_ready_off", {7'b0, ld_ready}, 8'h00);
        chk("t2_hold_tail", {7'b0, cpu_hold}, 8'h01);
        step();
        #2;
        chk("t2_hold_off", {7'b0, cpu_hold}, 8'h00);
        rd_lit("t2_ram100", 11'h100, 8'hAA);
        rd_lit("t2_ram101", 11'h101, 8'hBB);
        rd_lit("t2_ram102", 11'h102, 8'hCC);

        // 3: CPU store then read back same cycle
        cpu_wr(11'h005, 8'h5A);
        rd_lit("t3_ram005", 11'h005, 8'h5A);
        cpu_wr(11'h020, 8'h12);
        cpu_wr(11'h600, 8'h99);
        rd_lit("t3_unmapped", 11'h600, 8'h00);

        // 4: load across the top of RAM
        start();
        send(8'h01, 1'b0);
        send(8'hFF, 1'b0);
        send(8'h11, 1'b0);
        send(8'h22, 1'b1);
        step();
        rd_lit("t4_ram1ff", 11'h1FF, 8'h11);
        rd_lit("t4_ram200", 11'h200, 8'h00);

        // Pointer wraps from 0x7FF to 0x000
        start();
        send(8'h07, 1'b0);
        send(8'hFE, 1'b0);
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h03, 1'b1);
        step();
        rd_lit("wrap_ram000", 11'h000, 8'h03);

        // Loader and CPU write in the same cycle: loader wins
        start();
        send(8'h00, 1'b0);
        send(8'h30, 1'b0);
        rnw     = 1'b0;
        address = 11'h020;
        wdata   = 8'hEE;
        send(8'h44, 1'b1);
        rnw = 1'b1;
        step();
        rd_lit("coll_ram030", 11'h030, 8'h44);
        rd_lit("coll_ram020", 11'h020, 8'h12);

        // 5: I/O port
        port_in = 8'h81;
        cpu_wr(11'h7FF, 8'h3C);
`ifdef OPC_IO_PORT_EN
        #2;
        chk("t5_port_out", port_out, 8'h3C);
        rd_lit("t5_rd7fe", 11'h7FE, 8'h81);
        rd_lit("t5_rd7ff", 11'h7FF, 8'h3C);
`else
        #2;
        chk("t5_port_out", port_out, 8'h00);
        rd_lit("t5_rd7fe", 11'h7FE, 8'h00);
        rd_lit("t5_rd7ff", 11'h7FF, 8'h00);
`endif
        step();

        // 6: async reset in L_DATA after two data bytes
        start();
        send(8'h00, 1'b0);
        send(8'h10, 1'b0);
        send(8'h77, 1'b0);
        send(8'h88, 1'b0);
        rst_n = 1'b0;
        #2;
        chk("t6_hold", {7'b0, cpu_hold}, 8'h00);
        chk("t6_ready", {7'b0, ld_ready}, 8'h00);
        step();
        rst_n = 1'b1;
        step();
        rd_lit("t6_ram010", 11'h010, 8'h77);
        rd_lit("t6_ram011", 11'h011, 8'h88);
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
